// File: rtl/lfsr_pkg.sv
// Shared constants and single-shift helper for the parametrised LFSR generator.
package lfsr_pkg;

  localparam int unsigned MODE_FIB = 0;
  localparam int unsigned MODE_GAL = 1;
  localparam int unsigned MAX_W    = 32;

  // Primitive polynomials, bit i = coefficient of x^i, x^w implicit.
  function automatic logic [31:0] default_poly(input int unsigned w);
    logic [31:0] p;
    case (w)
      3:       p = 32'h0000_0003;
      4:       p = 32'h0000_0003;
      5:       p = 32'h0000_0009;
      6:       p = 32'h0000_0003;
      7:       p = 32'h0000_0003;
      8:       p = 32'h0000_001D;
      9:       p = 32'h0000_0011;
      10:      p = 32'h0000_0009;
      11:      p = 32'h0000_0005;
      12:      p = 32'h0000_0053;
      13:      p = 32'h0000_001B;
      14:      p = 32'h0000_0443;
      15:      p = 32'h0000_0003;
      16:      p = 32'h0000_100B;
      17:      p = 32'h0000_0009;
      18:      p = 32'h0000_0081;
      19:      p = 32'h0000_0027;
      20:      p = 32'h0000_0009;
      21:      p = 32'h0000_0005;
      22:      p = 32'h0000_0003;
      23:      p = 32'h0000_0021;
      24:      p = 32'h0000_0087;
      25:      p = 32'h0000_0009;
      26:      p = 32'h0000_0047;
      27:      p = 32'h0000_0027;
      28:      p = 32'h0000_0009;
      29:      p = 32'h0000_0005;
      30:      p = 32'h0000_0053;
      31:      p = 32'h0000_0009;
      32:      p = 32'h0040_0007;
      default: p = 32'h0000_0003;
    endcase
    return p;
  endfunction

  // One shift of a width-bit LFSR held right-aligned in 32 bits.
  // Returns {next_state, out_bit}.
  function automatic logic [32:0] lfsr_shift(input logic [31:0] state,
                                             input logic [31:0] poly,
                                             input int unsigned mode,
                                             input int unsigned width);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic        ob;
    logic        fb;
    mask = (width >= MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    ob   = state[5'(width - 1)];
    fb   = 1'b0;
    if (mode == MODE_FIB) begin
      for (int unsigned i = 0; i < MAX_W; i++) begin
        if (i < width) fb = fb ^ (poly[5'(i)] & state[5'(width - 1 - i)]);
      end
      nxt = ((state << 1) | {31'd0, fb}) & mask;
    end else begin
      nxt = ((state << 1) & mask) ^ (ob ? (poly & mask) : '0);
    end
    return {nxt, ob};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational STEP-fold unrolling of the single LFSR shift.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter int unsigned      MODE  = MODE_FIB,
  parameter int unsigned      STEP  = 1
)(
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state,
  output logic [STEP-1:0]  bits
);

  localparam logic [31:0] POLY32 = 32'(POLY);

  always_comb begin
    logic [31:0] s;
    logic [31:0] b;
    logic [32:0] r;
    s = 32'(state);
    b = '0;
    r = '0;
    // First-out bit ends up in the highest used position of b.
    for (int unsigned k = 0; k < STEP; k++) begin
      r = lfsr_shift(s, POLY32, MODE, WIDTH);
      b = {b[30:0], r[0]};
      s = r[32:1];
    end
    next_state = s[WIDTH-1:0];
    bits       = b[STEP-1:0];
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR PRBS generator with seed load and registered output.
// Optional period monitor enabled by defining LFSR_PERIOD_MON_EN.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h12),
  parameter int unsigned      MODE  = MODE_FIB,
  parameter int unsigned      STEP  = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_o,
  output logic [STEP-1:0]  dout,
  output logic             dout_vld,
  output logic             seed_zero,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 3..32");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_gen: STEP must be 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (POLY[0] != 1'b1) begin : g_bad_poly
    $error("lfsr_gen: POLY bit 0 must be set");
  end
  if (MODE > MODE_GAL) begin : g_bad_mode
    $error("lfsr_gen: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] state_q;
  logic [STEP-1:0]  dout_q;
  logic             vld_q;
  logic             sz_q;
  logic [WIDTH-1:0] step_next;
  logic [STEP-1:0]  step_bits;
  logic [WIDTH-1:0] load_val;
  logic             seed_is_zero;

  lfsr_step #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .MODE (MODE),
    .STEP (STEP)
  ) u_step (
    .state     (state_q),
    .next_state(step_next),
    .bits      (step_bits)
  );

  // A zero seed would lock the register; substitute 1 instead.
  always_comb begin
    seed_is_zero = (seed_in == '0);
    load_val     = seed_is_zero ? WIDTH'(1) : seed_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sz_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      sz_q  <= 1'b0;
      if (load) begin
        state_q <= load_val;
        sz_q    <= seed_is_zero;
      end else if (en) begin
        state_q <= step_next;
        dout_q  <= step_bits;
        vld_q   <= 1'b1;
      end
    end
  end

  assign state_o   = state_q;
  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign seed_zero = sz_q;

`ifdef LFSR_PERIOD_MON_EN
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] plen_q;
  logic             pdone_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= SEED;
      plen_q  <= '0;
      pdone_q <= 1'b0;
    end else begin
      pdone_q <= 1'b0;
      if (load) begin
        cnt_q   <= '0;
        start_q <= load_val;
        plen_q  <= '0;
      end else if (en) begin
        if (step_next == start_q) begin
          pdone_q <= 1'b1;
          plen_q  <= cnt_q + WIDTH'(1);
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end
  end

  assign period_done = pdone_q;
  assign period_len  = plen_q;
`else
  assign period_done = 1'b0;
  assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default Fibonacci, Galois and STEP=4 instances.
module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [4:0] seed_in;

  logic [4:0] f_state, g_state, s_state;
  logic       f_dout, g_dout;
  logic [3:0] s_dout;
  logic       f_vld, g_vld, s_vld;
  logic       f_sz, g_sz, s_sz;
  logic       f_pd, g_pd, s_pd;
  logic [4:0] f_pl, g_pl, s_pl;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

`ifdef LFSR_PERIOD_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  lfsr_gen dut_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state_o(f_state), .dout(f_dout), .dout_vld(f_vld), .seed_zero(f_sz),
    .period_done(f_pd), .period_len(f_pl)
  );

  lfsr_gen #(.MODE(1)) dut_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state_o(g_state), .dout(g_dout), .dout_vld(g_vld), .seed_zero(g_sz),
    .period_done(g_pd), .period_len(g_pl)
  );

  lfsr_gen #(.STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state_o(s_state), .dout(s_dout), .dout_vld(s_vld), .seed_zero(s_sz),
    .period_done(s_pd), .period_len(s_pl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The all-zero state must never appear in any instance.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("nz_fib", 32'(f_state != 5'd0), 32'd1);
      chk("nz_gal", 32'(g_state != 5'd0), 32'd1);
      chk("nz_s4",  32'(s_state != 5'd0), 32'd1);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 5'd0;
    tick(); tick();

    chk("rst_state",  32'(f_state), 32'h12);
    chk("rst_dout",   32'(f_dout),  32'h0);
    chk("rst_vld",    32'(f_vld),   32'h0);
    chk("rst_sz",     32'(f_sz),    32'h0);
    chk("rst_pd",     32'(f_pd),    32'h0);
    chk("rst_pl",     32'(f_pl),    32'h0);
    chk("rst_g_st",   32'(g_state), 32'h12);
    chk("rst_g_misc", 32'({g_dout, g_vld, g_sz, g_pd, g_pl}), 32'h0);
    chk("rst_s_st",   32'(s_state), 32'h12);
    chk("rst_s_misc", 32'({s_dout, s_vld, s_sz, s_pd, s_pl}), 32'h0);
    mon_on = 1'b1;

    rst = 1'b0; en = 1'b1;
    tick();
    chk("fib1_state", 32'(f_state), 32'h04);
    chk("fib1_dout",  32'(f_dout),  32'h1);
    chk("fib1_vld",   32'(f_vld),   32'h1);
    chk("gal1_state", 32'(g_state), 32'h0D);
    chk("gal1_dout",  32'(g_dout),  32'h1);
    chk("s4_state",   32'(s_state), 32'h01);
    chk("s4_dout",    32'(s_dout),  32'h9);
    chk("s4_vld",     32'(s_vld),   32'h1);

    en = 1'b0;
    tick();
    chk("hold_vld",   32'(f_vld),   32'h0);
    chk("hold_state", 32'(f_state), 32'h04);
    chk("hold_dout",  32'(f_dout),  32'h1);
    chk("hold_s4d",   32'(s_dout),  32'h9);

    en = 1'b1;
    tick();
    chk("fib2_state", 32'(f_state), 32'h08);
    chk("fib2_dout",  32'(f_dout),  32'h0);
    chk("fib2_vld",   32'(f_vld),   32'h1);

    // Full period from SEED.
    en = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 31; k++) begin
      tick();
      chk("per_seed", 32'(f_state == 5'h12), (k == 30) ? 32'd1 : 32'd0);
      chk("per_pd",   32'(f_pd), (MON && k == 30) ? 32'd1 : 32'd0);
      chk("per_pl",   32'(f_pl), (MON && k == 30) ? 32'd31 : 32'd0);
    end
    en = 1'b0;
    tick();
    chk("per_pd_end", 32'(f_pd), 32'd0);
    chk("per_pl_end", 32'(f_pl), MON ? 32'd31 : 32'd0);

    // Zero seed with en: load wins and 1 is substituted.
    load = 1'b1; seed_in = 5'd0; en = 1'b1;
    tick();
    chk("lz_state", 32'(f_state), 32'h01);
    chk("lz_sz",    32'(f_sz),    32'h1);
    chk("lz_vld",   32'(f_vld),   32'h0);
    chk("lz_pl",    32'(f_pl),    32'h0);
    load = 1'b0; en = 1'b0;
    tick();
    chk("lz_sz_off", 32'(f_sz),    32'h0);
    chk("lz_hold",   32'(f_state), 32'h01);

    load = 1'b1; seed_in = 5'h12;
    tick();
    chk("ls_state", 32'(f_state), 32'h12);
    chk("ls_sz",    32'(f_sz),    32'h0);
    load = 1'b0; en = 1'b1;
    tick();
    chk("ls_step",  32'(f_state), 32'h04);
    chk("ls_dout",  32'(f_dout),  32'h1);

    // Reset overrides load and en mid-stream.
    rst = 1'b1; load = 1'b1; seed_in = 5'd0; en = 1'b1;
    tick();
    chk("mr_state", 32'(f_state), 32'h12);
    chk("mr_dout",  32'(f_dout),  32'h0);
    chk("mr_vld",   32'(f_vld),   32'h0);
    chk("mr_sz",    32'(f_sz),    32'h0);
    chk("mr_pl",    32'(f_pl),    32'h0);
    chk("mr_s4d",   32'(s_dout),  32'h0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    tick();

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
